// File: rtl/boot_pkg.sv
// Shared types and constants for the imem boot loader.
package boot_pkg;

  localparam int unsigned BOOT_LEN_BYTES = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = 8 * BOOT_LEN_BYTES;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERROR
  } boot_state_e;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Boot byte stream (valid/ready) plus imem write port, grouped for the loader.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 8
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/boot_word_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; flags the completing byte combinationally.
module boot_word_packer
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  localparam int unsigned CNT_W   = 2;
  localparam int unsigned SHIFT_W = WORD_W - 8;

  logic [CNT_W-1:0]   cnt;
  logic [SHIFT_W-1:0] shift;

  assign word_valid_c = byte_valid && (cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign word_c       = {shift, byte_data};

  // Counter wraps naturally after the fourth byte of each word
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      shift <= '0;
    end else if (byte_valid) begin
      cnt   <= cnt + CNT_W'(1);
      shift <= {shift[SHIFT_W-9:0], byte_data};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed byte image into imem and holds the core in reset until done.
// Optional trailing XOR checksum byte enabled by BOOT_CHECKSUM_EN.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.slave   bus,
  output logic                core_reset,
  output logic                done,
  output logic                error
);

  boot_state_e       state, state_d;
  logic [LEN_W-1:0]  len, len_d;
  logic [LEN_W-1:0]  widx, widx_d;
  logic [LEN_W-1:0]  full_len;
  logic              we, we_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [31:0]       wdata, wdata_d;
  logic              core_reset_d, done_d, error_d;
  logic              xfer;
  logic              word_valid_c;
  logic [WORD_W-1:0] word_c;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum, csum_d;
`endif

  assign bus.in_ready   = (state == LEN_HI) || (state == LEN_LO) ||
                          (state == DATA)   || (state == CHK);
  assign xfer           = bus.in_valid && bus.in_ready;
  assign full_len       = {len[LEN_W-1 -: 8], bus.in_data};
  assign bus.imem_we    = we;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = wdata;

  boot_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .byte_valid   (xfer && (state == DATA)),
    .byte_data    (bus.in_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LEN_HI;
      len        <= '0;
      widx       <= '0;
      we         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_d;
      len        <= len_d;
      widx       <= widx_d;
      we         <= we_d;
      addr       <= addr_d;
      wdata      <= wdata_d;
      core_reset <= core_reset_d;
      done       <= done_d;
      error      <= error_d;
`ifdef BOOT_CHECKSUM_EN
      csum       <= csum_d;
`endif
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    len_d        = len;
    widx_d       = widx;
    we_d         = 1'b0;
    addr_d       = addr;
    wdata_d      = wdata;
    done_d       = done;
    error_d      = error;
    // core is released one cycle after done becomes visible
    core_reset_d = core_reset && !done;
`ifdef BOOT_CHECKSUM_EN
    csum_d       = csum;
`endif

    case (state)
      LEN_HI: begin
        if (xfer) begin
          len_d[LEN_W-1 -: 8] = bus.in_data;
          state_d             = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d = full_len;
          if (full_len == '0) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end else if (32'(full_len) > DEPTH) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
`ifdef BOOT_CHECKSUM_EN
          csum_d = csum ^ bus.in_data;
`endif
          if (word_valid_c) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'(widx);
            wdata_d = word_c;
            widx_d  = widx + LEN_W'(1);
            if ((widx + LEN_W'(1)) == len) begin
`ifdef BOOT_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = DONE;
              done_d  = 1'b1;
`endif
            end
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CHK: begin
        if (xfer) begin
          if (bus.in_data == csum) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
      end
`endif
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

endmodule
